qbus_dma_master: RTL

QBUS_DMA_MASTER -- requirements
Module: qbus_dma_master

---
 rtl/qbus_pkg.sv | 20 ++
 rtl/qbus_sync.sv | 22 ++
 rtl/qbus_dma_master.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/qbus_pkg.sv
// Shared definitions for the QBUS DMA bus master.
// State encoding, timeout limit and address setup length.
package qbus_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WGNT,
        S_WBUS,
        S_ADDR,
        S_ASYN,
        S_DSET,
        S_DATA,
        S_DNEG
    } qbus_state_e;

    localparam int          TMO_W      = 8;
    localparam logic [7:0]  TMO_LIMIT  = 8'd255;
    localparam logic [1:0]  ADDR_SETUP = 2'd2;

endpackage

// File: rtl/qbus_sync.sv
// Two-flop synchronizer for asynchronous active-low QBUS inputs.
// Resets to the negated (high) level.
module qbus_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/qbus_dma_master.sv
// QBUS DMA bus master: arbitrates for the bus and runs one DATI,
// DATO or DATOB cycle per local request, with RPLY timeout.
module qbus_dma_master
    import qbus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic        bmode,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic        err,
    output logic [15:0] rdata,
    input  logic [15:0] ad_in,
    output logic [15:0] ad_out,
    output logic        ad_oe,
    output logic        sync_n,
    output logic        din_n,
    output logic        dout_n,
    output logic        wtbt_n,
    input  logic        rply_n,
    output logic        dmr_n,
    input  logic        dmgi_n,
    output logic        sack_n,
    input  logic        init_n
);

    logic rply_s;
    logic dmgi_s;
    logic init_s;

    qbus_sync u_sync_rply (.clk(clk), .rst(rst), .d_i(rply_n), .q_o(rply_s));
    qbus_sync u_sync_dmgi (.clk(clk), .rst(rst), .d_i(dmgi_n), .q_o(dmgi_s));
    qbus_sync u_sync_init (.clk(clk), .rst(rst), .d_i(init_n), .q_o(init_s));

    qbus_state_e      state_q;
    logic [15:0]      addr_q;
    logic [15:0]      wdata_q;
    logic             we_q;
    logic             bmode_q;
    logic [1:0]       setup_q;
    logic [TMO_W-1:0] tmo_q;
    logic [TMO_W-1:0] tmo_d;

    logic        ack_q;
    logic        err_q;
    logic [15:0] rdata_q;
    logic [15:0] ad_out_q;
    logic        ad_oe_q;
    logic        sync_n_q;
    logic        din_n_q;
    logic        dout_n_q;
    logic        wtbt_n_q;
    logic        dmr_n_q;
    logic        sack_n_q;

    assign tmo_d = tmo_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            we_q     <= 1'b0;
            bmode_q  <= 1'b0;
            setup_q  <= 2'd0;
            tmo_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 16'h0000;
            ad_out_q <= 16'hFFFF;
            ad_oe_q  <= 1'b0;
            sync_n_q <= 1'b1;
            din_n_q  <= 1'b1;
            dout_n_q <= 1'b1;
            wtbt_n_q <= 1'b1;
            dmr_n_q  <= 1'b1;
            sack_n_q <= 1'b1;
        end else if (!init_s) begin
            // Bus INIT aborts silently: no ack, rdata untouched.
            state_q  <= S_IDLE;
            setup_q  <= 2'd0;
            tmo_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            ad_out_q <= 16'hFFFF;
            ad_oe_q  <= 1'b0;
            sync_n_q <= 1'b1;
            din_n_q  <= 1'b1;
            dout_n_q <= 1'b1;
            wtbt_n_q <= 1'b1;
            dmr_n_q  <= 1'b1;
            sack_n_q <= 1'b1;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        we_q    <= we;
                        bmode_q <= bmode;
                        dmr_n_q <= 1'b0;
                        state_q <= S_WGNT;
                    end
                end
                S_WGNT: begin
                    if (!dmgi_s) begin
                        sack_n_q <= 1'b0;
                        dmr_n_q  <= 1'b1;
                        state_q  <= S_WBUS;
                    end
                end
                S_WBUS: begin
                    // A stale RPLY from the previous master blocks us.
                    if (rply_s) begin
                        ad_oe_q  <= 1'b1;
                        ad_out_q <= ~addr_q;
                        wtbt_n_q <= ~we_q;
                        setup_q  <= 2'd0;
                        state_q  <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    setup_q <= setup_q + 2'd1;
                    if (setup_q == ADDR_SETUP - 2'd1) begin
                        sync_n_q <= 1'b0;
                        state_q  <= S_ASYN;
                    end
                end
                S_ASYN: begin
                    if (we_q) begin
                        ad_out_q <= ~wdata_q;
                        wtbt_n_q <= ~bmode_q;
                    end else begin
                        ad_oe_q  <= 1'b0;
                    end
                    state_q <= S_DSET;
                end
                S_DSET: begin
                    if (we_q) begin
                        dout_n_q <= 1'b0;
                    end else begin
                        din_n_q  <= 1'b0;
                    end
                    tmo_q   <= '0;
                    state_q <= S_DATA;
                end
                S_DATA: begin
                    if (!rply_s) begin
                        if (!we_q) begin
                            rdata_q <= ~ad_in;
                        end
                        din_n_q  <= 1'b1;
                        dout_n_q <= 1'b1;
                        state_q  <= S_DNEG;
                    end else if (tmo_d == TMO_LIMIT) begin
                        tmo_q    <= tmo_d;
                        ad_out_q <= 16'hFFFF;
                        ad_oe_q  <= 1'b0;
                        sync_n_q <= 1'b1;
                        din_n_q  <= 1'b1;
                        dout_n_q <= 1'b1;
                        wtbt_n_q <= 1'b1;
                        sack_n_q <= 1'b1;
                        ack_q    <= 1'b1;
                        err_q    <= 1'b1;
                        state_q  <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                S_DNEG: begin
                    if (rply_s) begin
                        ad_out_q <= 16'hFFFF;
                        ad_oe_q  <= 1'b0;
                        sync_n_q <= 1'b1;
                        wtbt_n_q <= 1'b1;
                        sack_n_q <= 1'b1;
                        ack_q    <= 1'b1;
                        state_q  <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack    = ack_q;
    assign err    = err_q;
    assign rdata  = rdata_q;
    assign ad_out = ad_out_q;
    assign ad_oe  = ad_oe_q;
    assign sync_n = sync_n_q;
    assign din_n  = din_n_q;
    assign dout_n = dout_n_q;
    assign wtbt_n = wtbt_n_q;
    assign dmr_n  = dmr_n_q;
    assign sack_n = sack_n_q;

endmodule
